// File: rtl/length_finder.sv
// length_finder: registered count of characters before the first null byte
// in a packed 8-character string (character 0 is the most significant byte).
// The SystemVerilog keyword "string" cannot be used as a port name, so the
// string input is named "str".
module length_finder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [63:0] str,
    output logic [3:0]  length,
    output logic        out_valid
);

    logic [3:0] len_next;
    logic       found;

    // Priority search: the lowest-numbered all-zero byte sets the length;
    // later bytes (including further nulls) are ignored. No null gives 8.
    always_comb begin
        len_next = 4'd8;
        found    = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (!found && (str[63 - 8*k -: 8] == 8'h00)) begin
                len_next = 4'(k);
                found    = 1'b1;
            end
        end
    end

    // Result register: loads on in_valid, otherwise holds; out_valid pulses one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            length    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                length <= len_next;
            end
        end
    end

endmodule

// File: tb/tb_length_finder.sv
// tb_length_finder: directed, table-driven checks of length_finder.
module tb_length_finder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] str;
    logic [3:0]  length;
    logic        out_valid;

    int checks;
    int errors;

    typedef struct {
        logic [63:0] s;
        logic [3:0]  exp_len;
    } vec_t;

    vec_t vecs [14];

    length_finder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .str       (str),
        .length    (length),
        .out_valid (out_valid)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        str      = '0;

        vecs[0]  = '{64'hAABBCCDDEEFFAA00, 4'd7};
        vecs[1]  = '{64'hAABBCCDDEEFFAA99, 4'd8};
        vecs[2]  = '{64'h44BBC00DEE44FFAA, 4'd8};
        vecs[3]  = '{64'hAABBCCDDEEFF00AA, 4'd6};
        vecs[4]  = '{64'hAABBCCDDEE00FFAA, 4'd5};
        vecs[5]  = '{64'hAABBCC00EE00FFAA, 4'd3};
        vecs[6]  = '{64'h00BBCCDDEE44FFAA, 4'd0};
        vecs[7]  = '{64'h00BBCC00EE44FFAA, 4'd0};
        vecs[8]  = '{64'h0000000000000000, 4'd0};
        vecs[9]  = '{64'hAA00BBCCDDEEFF11, 4'd1};
        vecs[10] = '{64'hAABB00CCDDEEFF11, 4'd2};
        vecs[11] = '{64'hAABBCCDD00EEFF11, 4'd4};
        vecs[12] = '{64'h0DC00DC00DC00DC0, 4'd8};
        vecs[13] = '{64'hAABBCCDDEEFF0000, 4'd6};

        // Reset state, including across clock edges
        repeat (2) @(posedge clk);
        #1;
        check("reset_length", 64'(length), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back table vectors: one result per cycle
        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid = 1'b1;
            str      = vecs[i].s;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_length", i), 64'(length), 64'(vecs[i].exp_len));
            check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'd1);
        end

        // Drop in_valid: out_valid clears, length holds even if str changes
        @(negedge clk);
        in_valid = 1'b0;
        str      = 64'h00BBCCDDEEFFAA11;
        @(posedge clk);
        #1;
        check("idle_out_valid", 64'(out_valid), 64'd0);
        check("idle_length_hold", 64'(length), 64'd6);
        @(posedge clk);
        #1;
        check("idle2_out_valid", 64'(out_valid), 64'd0);
        check("idle2_length_hold", 64'(length), 64'd6);

        // Three-string burst then idle
        @(negedge clk);
        in_valid = 1'b1;
        str      = 64'hAABBCCDDEE00FFAA;
        @(posedge clk);
        #1;
        check("burst0_length", 64'(length), 64'd5);
        check("burst0_out_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        str = 64'hAABBCCDDEEFFAA99;
        @(posedge clk);
        #1;
        check("burst1_length", 64'(length), 64'd8);
        check("burst1_out_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        str = 64'hAA00CCDDEEFFAA99;
        @(posedge clk);
        #1;
        check("burst2_length", 64'(length), 64'd1);
        check("burst2_out_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        str      = '0;
        @(posedge clk);
        #1;
        check("burst_end_out_valid", 64'(out_valid), 64'd0);
        check("burst_end_length", 64'(length), 64'd1);

        // Load length=8, then assert reset between edges
        @(negedge clk);
        in_valid = 1'b1;
        str      = 64'h1122334455667788;
        @(posedge clk);
        #1;
        check("pre_reset_length", 64'(length), 64'd8);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_length", 64'(length), 64'd0);
        check("async_reset_out_valid", 64'(out_valid), 64'd0);

        // Release and apply a fresh string
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        str      = 64'hAABBCCDDEEFFAA00;
        @(posedge clk);
        #1;
        check("post_reset_length", 64'(length), 64'd7);
        check("post_reset_out_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_idle_out_valid", 64'(out_valid), 64'd0);
        check("post_reset_idle_length", 64'(length), 64'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/length_finder.md
LENGTH_FINDER -- requirements
Module: length_finder

Interface
REQ-001 The block SHALL have no parameters; string width fixed at 64 bits (8 bytes), length width fixed at 4 bits.
REQ-002 clk  input  1  rising-edge clock; all state SHALL update only on clk rising edge or rst_n assertion.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  when high, string is sampled on the current clk rising edge.
REQ-005 string  input  64  packed 8-character string; character 0 = string[63:56], character k = string[63-8k -: 8], character 7 = string[7:0].
REQ-006 length  output  4  registered count of characters before the first null byte (range 0..8).
REQ-007 out_valid  output  1  registered; high for one cycle when length holds a newly computed result.

Function
REQ-008 Null byte SHALL be defined as a character equal to 8'h00; a byte with only one zero nibble (e.g. 8'h0D, 8'hC0) SHALL NOT be null.
REQ-009 Computed length SHALL be the index k of the lowest-numbered null character (character 0 = MSB byte).
REQ-010 If no character is null, computed length SHALL be 8 (4'b1000).
REQ-011 Characters after the first null SHALL NOT affect the result, including further null bytes.
REQ-012 On a clk rising edge with in_valid=1, length SHALL load the computed length of string and out_valid SHALL be set to 1.
REQ-013 On a clk rising edge with in_valid=0, length SHALL hold its previous value and out_valid SHALL be cleared to 0.
REQ-014 Latency SHALL be exactly one cycle: result for a string sampled at edge N is visible after edge N and out_valid is high during cycle N+1 only.
REQ-015 Back-to-back in_valid SHALL be supported at full rate (one result per cycle, no stalls, no backpressure).
REQ-016 The null search SHALL be purely combinational from string to the length register input; no multi-cycle scanning.
REQ-017 length values 9..15 SHALL never be produced.
REQ-018 Outputs SHALL have no combinational path from any input.

Reset
REQ-019 While rst_n=0, length SHALL be 4'd0 and out_valid SHALL be 0, asserted immediately (asynchronously), independent of clk.
REQ-020 Reset asserted mid-stream SHALL discard any in-flight result; the first edge after rst_n deasserts SHALL behave per REQ-012/REQ-013.
REQ-021 No X SHALL propagate to outputs after reset for any known string value.

Verification
REQ-022 string=64'hAABBCCDDEEFFAA00, in_valid=1 -> next cycle length=7, out_valid=1.
REQ-023 string=64'hAABBCCDDEEFFAA99 (no null) -> length=8; string=64'h44BBC00DEE44FFAA (zero nibbles, no null byte) -> length=8.
REQ-024 string=64'hAABBCCDDEEFF00AA -> length=6; 64'hAABBCCDDEE00FFAA -> 5; 64'hAABBCC00EE00FFAA -> 3 (first null wins).
REQ-025 string=64'h00BBCCDDEE44FFAA -> 0; 64'h00BBCC00EE44FFAA -> 0; string=64'h0 -> 0.
REQ-026 Stream 3 strings back-to-back with in_valid=1 then drop in_valid -> three consecutive out_valid pulses with matching lengths, then out_valid=0 and length holds last value.
REQ-027 Assert rst_n=0 between clk edges while length=8 -> length=0 and out_valid=0 immediately; release and apply 64'hAABBCCDDEEFFAA00 -> length=7 one cycle later.
